pic_host_master: RTL and testbench

CPU-side bus master for the 8259A interrupt controller: it is the initiator that drives the controller's chip-select, read, write, A0 and interrupt-acknowledge pins. The block turns single-beat register commands from the core (ICW/OCW writes, IRR/ISR/IMR reads) into timed strobe cycles. It also answers the controller's interrupt request with an 8086-mode acknowledge sequence of two INTA pulses and returns the captured vector to the core. It sits between the core's bus unit and the interrupt controller's pins.

---
 rtl/pic_host_pkg.sv | 28 ++
 rtl/pic_strobe_timer.sv | 28 ++
 rtl/pic_host_master.sv | 175 +++++++++++++++++
 tb/tb_pic_host_master.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pic_host_pkg.sv
// Shared types for the 8259A host-side bus master: FSM state encoding and latched command.
// No logic beyond a phase-classification helper.
// Not applicable: no flow control lives here.
package pic_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_STROBE,
        RD_STROBE,
        CMD_GAP,
        ACK1,
        ACK_GAP,
        ACK2,
        ACK_END
    } state_t;

    typedef struct packed {
        logic       write;
        logic       a0;
        logic [7:0] data;
    } cmd_t;

    // Strobe-low phases use STROBE_CYCLES; every other timed phase uses GAP_CYCLES.
    function automatic logic is_strobe_phase(input state_t s);
        return (s == WR_STROBE) || (s == RD_STROBE) || (s == ACK1) || (s == ACK2);
    endfunction

endpackage

// File: rtl/pic_strobe_timer.sv
// Loadable down-counter timing one strobe or gap phase; done while the count is zero.
// Latency: load takes effect on the next edge, done is a decode of the count register.
// No backpressure: load always wins over counting.
module pic_strobe_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/pic_host_master.sv
// 8259A bus master: register read/write strobe cycles and the two-pulse 8086 INTA sequence.
// Latency: write/read 2+STROBE+GAP-1 cycles to ready, acknowledge 3*... see timing below; all pins registered.
// Backpressure: cmd_ready low outside IDLE and whenever an acknowledge is starting.
module pic_host_master
    import pic_host_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       int_enable,
    output logic       vector_valid,
    output logic [7:0] vector,
    output logic       int_busy,
    input  logic       interrupt_to_cpu,
    output logic       interrupt_acknowledge_n,
    output logic       chip_select_n,
    output logic       read_enable_n,
    output logic       write_enable_n,
    output logic       address,
    input  logic [7:0] data_bus_in,
    output logic [7:0] data_bus_out,
    output logic       data_bus_io
);

    localparam int MAX_CYCLES = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_t           state;
    state_t           next_state;
    cmd_t             cmd_q;
    cmd_t             cmd_d;
    logic             int_req;
    logic             accept;
    logic             timer_load;
    logic             timer_done;
    logic [CNT_W-1:0] timer_val;
    logic             cs_n_d;
    logic             rd_n_d;
    logic             wr_n_d;
    logic             inta_n_d;
    logic             io_d;
    logic             busy_d;
    logic             rd_last;
    logic             ack_last;

    assign int_req   = interrupt_to_cpu & int_enable;
    assign cmd_ready = reset_n & (state == IDLE) & ~int_req;
    assign accept    = cmd_valid & cmd_ready;
    assign cmd_d     = accept ? cmd_t'{write: cmd_write, a0: cmd_a0, data: cmd_data} : cmd_q;
    assign rd_last   = (state == RD_STROBE) && timer_done;
    assign ack_last  = (state == ACK2) && timer_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Acknowledge wins in IDLE; every other phase just waits for its timer.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (int_req) begin
                    next_state = ACK1;
                end else if (cmd_valid) begin
                    next_state = cmd_write ? WR_STROBE : RD_STROBE;
                end
            end
            WR_STROBE: if (timer_done) next_state = CMD_GAP;
            RD_STROBE: if (timer_done) next_state = CMD_GAP;
            CMD_GAP:   if (timer_done) next_state = IDLE;
            ACK1:      if (timer_done) next_state = ACK_GAP;
            ACK_GAP:   if (timer_done) next_state = ACK2;
            ACK2:      if (timer_done) next_state = ACK_END;
            ACK_END:   if (timer_done) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    assign timer_load = (next_state != state);
    assign timer_val  = is_strobe_phase(next_state) ? CNT_W'(STROBE_CYCLES - 1)
                                                    : CNT_W'(GAP_CYCLES - 1);

    pic_strobe_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // Pin values for the coming cycle, decoded from next_state so the pins themselves are flops.
    always_comb begin
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        inta_n_d = 1'b1;
        io_d     = 1'b0;
        busy_d   = 1'b0;
        case (next_state)
            WR_STROBE: begin
                cs_n_d = 1'b0;
                wr_n_d = 1'b0;
                io_d   = cmd_d.write;
            end
            RD_STROBE: begin
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
            end
            ACK1, ACK2: begin
                inta_n_d = 1'b0;
                busy_d   = 1'b1;
            end
            ACK_GAP, ACK_END: busy_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chip_select_n           <= 1'b1;
            read_enable_n           <= 1'b1;
            write_enable_n          <= 1'b1;
            interrupt_acknowledge_n <= 1'b1;
            data_bus_io             <= 1'b0;
            int_busy                <= 1'b0;
            cmd_q                   <= '0;
        end else begin
            chip_select_n           <= cs_n_d;
            read_enable_n           <= rd_n_d;
            write_enable_n          <= wr_n_d;
            interrupt_acknowledge_n <= inta_n_d;
            data_bus_io             <= io_d;
            int_busy                <= busy_d;
            cmd_q                   <= cmd_d;
        end
    end

    assign address      = cmd_q.a0;
    assign data_bus_out = cmd_q.data;

    // Vector byte is passed through untouched, including the IR7 spurious vector.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            vector_valid <= 1'b0;
            vector       <= '0;
        end else begin
            rsp_valid    <= rd_last;
            vector_valid <= ack_last;
            if (rd_last) begin
                rsp_data <= data_bus_in;
            end
            if (ack_last) begin
                vector <= data_bus_in;
            end
        end
    end

endmodule

// File: tb/tb_pic_host_master.sv
// Directed bench for pic_host_master with hand-derived cycle-by-cycle expectations.
module tb_pic_host_master;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic       cmd_a0;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       int_enable;
    logic       vector_valid;
    logic [7:0] vector;
    logic       int_busy;
    logic       interrupt_to_cpu;
    logic       interrupt_acknowledge_n;
    logic       chip_select_n;
    logic       read_enable_n;
    logic       write_enable_n;
    logic       address;
    logic [7:0] data_bus_in;
    logic [7:0] data_bus_out;
    logic       data_bus_io;

    int n_checks = 0;
    int n_fail   = 0;

    pic_host_master #(
        .STROBE_CYCLES(2),
        .GAP_CYCLES   (1)
    ) dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_write               (cmd_write),
        .cmd_a0                  (cmd_a0),
        .cmd_data                (cmd_data),
        .rsp_valid               (rsp_valid),
        .rsp_data                (rsp_data),
        .int_enable              (int_enable),
        .vector_valid            (vector_valid),
        .vector                  (vector),
        .int_busy                (int_busy),
        .interrupt_to_cpu        (interrupt_to_cpu),
        .interrupt_acknowledge_n (interrupt_acknowledge_n),
        .chip_select_n           (chip_select_n),
        .read_enable_n           (read_enable_n),
        .write_enable_n          (write_enable_n),
        .address                 (address),
        .data_bus_in             (data_bus_in),
        .data_bus_out            (data_bus_out),
        .data_bus_io             (data_bus_io)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Caller has raised INT in IDLE (cycle 0); walks cycles 1..7 of the acknowledge.
    task automatic ack_seq(input logic [7:0] vec, input int drop_cycle);
        logic exp_inta;
        data_bus_in = vec;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == drop_cycle) interrupt_to_cpu = 1'b0;
            exp_inta = !(c == 1 || c == 2 || c == 4 || c == 5);
            check($sformatf("ack_inta_c%0d", c), interrupt_acknowledge_n, exp_inta);
            check($sformatf("ack_busy_c%0d", c), int_busy, (c <= 6));
            check($sformatf("ack_cs_c%0d", c), chip_select_n, 1'b1);
            check($sformatf("ack_vv_c%0d", c), vector_valid, (c == 6));
            if (c < 7) check($sformatf("ack_ready_c%0d", c), cmd_ready, 1'b0);
            if (c == 6) check("ack_vector", vector, vec);
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        cmd_valid        = 1'b0;
        cmd_write        = 1'b0;
        cmd_a0           = 1'b0;
        cmd_data         = 8'h00;
        int_enable       = 1'b0;
        interrupt_to_cpu = 1'b0;
        data_bus_in      = 8'h00;

        // Reset state
        tick();
        tick();
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_strobes", {chip_select_n, read_enable_n, write_enable_n, interrupt_acknowledge_n}, 4'hF);
        check("rst_bus", {address, data_bus_io, data_bus_out}, 10'h0);
        check("rst_rsp", {rsp_valid, rsp_data}, 9'h0);
        check("rst_vec", {vector_valid, vector, int_busy}, 10'h0);
        reset_n = 1'b1;
        #1;
        check("first_idle_ready", cmd_ready, 1'b1);

        // Write a0=0 data=0x13
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_a0 = 1'b0; cmd_data = 8'h13;
        #1;
        check("wr_accept_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0; cmd_data = 8'h00;
        check("wr_c1_strobes", {chip_select_n, write_enable_n, read_enable_n}, 3'b001);
        check("wr_c1_bus", {address, data_bus_io, data_bus_out}, {1'b0, 1'b1, 8'h13});
        tick();
        check("wr_c2_wr", write_enable_n, 1'b0);
        check("wr_c2_dout", data_bus_out, 8'h13);
        tick();
        check("wr_c3_strobes", {chip_select_n, write_enable_n, data_bus_io}, 3'b110);
        check("wr_c3_ready", cmd_ready, 1'b0);
        tick();
        check("wr_c4_ready", cmd_ready, 1'b1);

        // Read a0=1, controller drives 0xFB
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_a0 = 1'b1; data_bus_in = 8'hFB;
        tick();
        cmd_valid = 1'b0;
        check("rd_c1_strobes", {chip_select_n, read_enable_n, write_enable_n}, 3'b001);
        check("rd_c1_bus", {address, data_bus_io}, 2'b10);
        tick();
        check("rd_c2_rd", read_enable_n, 1'b0);
        check("rd_c2_rv", rsp_valid, 1'b0);
        tick();
        check("rd_c3_rd", read_enable_n, 1'b1);
        check("rd_c3_rsp", {rsp_valid, rsp_data}, {1'b1, 8'hFB});
        tick();
        data_bus_in = 8'h00;
        check("rd_c4_rv", rsp_valid, 1'b0);
        check("rd_c4_hold", rsp_data, 8'hFB);
        check("rd_c4_ready", cmd_ready, 1'b1);

        // Acknowledge, vector 0x20
        int_enable = 1'b1; interrupt_to_cpu = 1'b1;
        #1;
        check("ack_c0_ready", cmd_ready, 1'b0);
        ack_seq(8'h20, 1);
        check("ack_end_ready", cmd_ready, 1'b1);

        // Command and INT together: acknowledge first, then the write
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_data = 8'hA5;
        interrupt_to_cpu = 1'b1;
        #1;
        check("both_c0_ready", cmd_ready, 1'b0);
        ack_seq(8'h48, 1);
        check("both_c7_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("both_wr_strobes", {chip_select_n, write_enable_n, interrupt_acknowledge_n}, 3'b001);
        check("both_wr_bus", {address, data_bus_out}, {1'b1, 8'hA5});
        tick();
        tick();
        tick();
        check("both_idle_ready", cmd_ready, 1'b1);

        // INT dropped during ACK_GAP still completes
        interrupt_to_cpu = 1'b1;
        ack_seq(8'h27, 3);
        check("drop_vector_hold", vector, 8'h27);

        // INT ignored while disabled
        int_enable = 1'b0; interrupt_to_cpu = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_a0 = 1'b0; cmd_data = 8'h55;
        #1;
        check("dis_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("dis_wr", {write_enable_n, interrupt_acknowledge_n, int_busy}, 3'b010);
        check("dis_dout", data_bus_out, 8'h55);
        tick();
        tick();
        tick();
        interrupt_to_cpu = 1'b0;
        check("dis_idle", {cmd_ready, interrupt_acknowledge_n}, 2'b11);

        // Reset pulsed in the middle of ACK2
        int_enable = 1'b1; interrupt_to_cpu = 1'b1; data_bus_in = 8'h66;
        for (int c = 1; c <= 4; c++) tick();
        interrupt_to_cpu = 1'b0;
        check("mid_ack2_inta", interrupt_acknowledge_n, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_inta", interrupt_acknowledge_n, 1'b1);
        check("mid_rst_busy", int_busy, 1'b0);
        check("mid_rst_ready", cmd_ready, 1'b0);
        tick();
        check("mid_rst_vv", vector_valid, 1'b0);
        reset_n = 1'b1;
        #1;
        check("mid_rel_ready", cmd_ready, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("mid_post_c%0d", c), {vector_valid, interrupt_acknowledge_n, int_busy}, 3'b010);
        end
        check("mid_vector_cleared", vector, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
